// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART line echo front end.
package uart_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_BS = 8'h08;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_ECHO    = 2'd1,
    S_CR      = 2'd2,
    S_LF      = 2'd3
  } state_t;

endpackage

// File: rtl/line_buf_ram.sv
// Line buffer storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner tracks which entries are valid.
module line_buf_ram #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  // Store one character per write strobe.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_line_echo.sv
// Console line editor: pops RX bytes into a line buffer (with backspace),
// and on the terminator echoes the line into the TX FIFO followed by CR, LF.
// Optional feature macro: UART_ECHO_UPCASE_EN (upper-cases a..z on echo only).
module uart_line_echo
  import uart_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter int                   LINE_MAX  = 32,
  parameter int                   LEN_BITS  = 6,
  parameter logic [DATA_BITS-1:0] TERM_CHAR = DATA_BITS'(8'h0D)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_empty,
  input  logic [DATA_BITS-1:0] read_data,
  output logic                 read_uart,
  input  logic                 tx_full,
  output logic                 write_uart,
  output logic [DATA_BITS-1:0] write_data,
  output logic [LEN_BITS-1:0]  line_len,
  output logic                 busy,
  output logic                 line_done,
  output logic                 overflow
);

  localparam int ADDR_BITS = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_BITS-1:0]   r_count;
  logic [LEN_BITS-1:0]   w_count_next;
  logic [LEN_BITS-1:0]   r_idx;
  logic [LEN_BITS-1:0]   w_idx_next;
  logic                  r_overflow;
  logic                  w_overflow_next;
  logic                  r_line_done;
  logic                  w_line_done_next;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_buf_we;
  logic [DATA_BITS-1:0]  w_rd_data;

  // Echo-time character mapping; the stored buffer is never altered.
  function automatic logic [DATA_BITS-1:0] conv(input logic [DATA_BITS-1:0] c);
`ifdef UART_ECHO_UPCASE_EN
    if ((c >= DATA_BITS'(8'h61)) && (c <= DATA_BITS'(8'h7A))) begin
      return c - DATA_BITS'(8'h20);
    end
    return c;
`else
    return c;
`endif
  endfunction

  line_buf_ram #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (LINE_MAX),
    .ADDR_BITS(ADDR_BITS)
  ) u_line_buf (
    .clk    (clk),
    .i_we   (w_buf_we),
    .i_waddr(r_count[ADDR_BITS-1:0]),
    .i_wdata(read_data),
    .i_raddr(r_idx[ADDR_BITS-1:0]),
    .o_rdata(w_rd_data)
  );

  // State, counters and status flags; reset discards any partial line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_COLLECT;
      r_count     <= '0;
      r_idx       <= '0;
      r_overflow  <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_idx       <= w_idx_next;
      r_overflow  <= w_overflow_next;
      r_line_done <= w_line_done_next;
    end
  end

  // Next-state logic plus the combinational FIFO strobes and TX data mux.
  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_idx_next       = r_idx;
    w_overflow_next  = r_overflow;
    w_line_done_next = 1'b0;
    w_buf_we         = 1'b0;
    w_pop            = (r_state == S_COLLECT) && !rx_empty;
    w_push           = (r_state != S_COLLECT) && !tx_full;
    write_data       = '0;

    case (r_state)
      S_COLLECT: begin
        if (w_pop) begin
          if (read_data == TERM_CHAR) begin
            w_idx_next   = '0;
            w_state_next = (r_count == '0) ? S_CR : S_ECHO;
          end else if (read_data == DATA_BITS'(CHAR_BS)) begin
            if (r_count != '0) begin
              w_count_next = r_count - LEN_BITS'(1);
            end
          end else if (r_count < LEN_BITS'(LINE_MAX)) begin
            w_buf_we     = 1'b1;
            w_count_next = r_count + LEN_BITS'(1);
          end else begin
            w_overflow_next = 1'b1;
          end
        end
      end
      S_ECHO: begin
        write_data = conv(w_rd_data);
        if (w_push) begin
          w_idx_next = r_idx + LEN_BITS'(1);
          if (r_idx == (r_count - LEN_BITS'(1))) begin
            w_state_next = S_CR;
          end
        end
      end
      S_CR: begin
        write_data = DATA_BITS'(CHAR_CR);
        if (w_push) begin
          w_state_next = S_LF;
        end
      end
      S_LF: begin
        write_data = DATA_BITS'(CHAR_LF);
        if (w_push) begin
          w_count_next     = '0;
          w_overflow_next  = 1'b0;
          w_line_done_next = 1'b1;
          w_state_next     = S_COLLECT;
        end
      end
      default: begin
        w_state_next = S_COLLECT;
      end
    endcase
  end

  assign read_uart  = w_pop;
  assign write_uart = w_push;
  assign line_len   = r_count;
  assign busy       = (r_state != S_COLLECT);
  assign line_done  = r_line_done;
  assign overflow   = r_overflow;

endmodule
